tmr_recovery_ctrl: RTL

TMR_RECOVERY_CTRL -- requirements
Module: tmr_recovery_ctrl

---
 rtl/tmr_pkg.sv | 54 +++++
 rtl/ckpt_ring.sv | 44 ++++
 rtl/tmr_recovery_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/tmr_pkg.sv
// Shared types for the TMR recovery controller: FSM states, voter patterns,
// faulty-core codes and the voter decode helper.
package tmr_pkg;

   typedef enum logic [2:0] {
      ST_RUN,
      ST_MASK,
      ST_STALL,
      ST_RESYNC,
      ST_RELOAD,
      ST_VERIFY,
      ST_FATAL
   } state_e;

   localparam logic [2:0] AGREE = 3'b111;
   localparam logic [2:0] A_BAD = 3'b010;
   localparam logic [2:0] B_BAD = 3'b001;
   localparam logic [2:0] C_BAD = 3'b100;

   localparam logic [1:0] CORE_NONE = 2'd0;
   localparam logic [1:0] CORE_A    = 2'd1;
   localparam logic [1:0] CORE_B    = 2'd2;
   localparam logic [1:0] CORE_C    = 2'd3;

   // DEC_IDLE exists only between reset and the first captured voter sample.
   typedef enum logic [1:0] {
      DEC_IDLE,
      DEC_AGREE,
      DEC_SINGLE,
      DEC_NOMAJ
   } dec_e;

   typedef struct packed {
      dec_e       kind;
      logic [1:0] core;
   } decode_t;

   function automatic decode_t decode_voter(input logic [2:0] vs, input logic hold);
      decode_t d;
      d.kind = DEC_NOMAJ;
      d.core = CORE_NONE;
      if (!hold) begin
         case (vs)
            AGREE:   d.kind = DEC_AGREE;
            A_BAD:   begin d.kind = DEC_SINGLE; d.core = CORE_A; end
            B_BAD:   begin d.kind = DEC_SINGLE; d.core = CORE_B; end
            C_BAD:   begin d.kind = DEC_SINGLE; d.core = CORE_C; end
            default: d.kind = DEC_NOMAJ;
         endcase
      end
      return d;
   endfunction

endpackage

// File: rtl/ckpt_ring.sv
// Circular buffer of checkpointed PCs; reads are addressed by depth below
// the newest entry and fall back to RESET_PC past the valid entries.
module ckpt_ring #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0,
   localparam int         PTR_W    = $clog2(DEPTH),
   localparam int         CNT_W    = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_in,
   input  logic             push,
   input  logic [31:0]      pc_in,
   input  logic [CNT_W-1:0] rd_depth,
   output logic [31:0]      rd_pc,
   output logic [CNT_W-1:0] count,
   output logic [31:0]      newest
);

   logic [31:0]      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] newest_idx;
   logic [PTR_W-1:0] rd_idx;

   // NOTE: storage has no reset; count alone says which entries are meaningful.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= pc_in;
   end

   always_ff @(posedge clk) begin
      if (rst_in) begin
         wr_ptr <= '0;
         count  <= '0;
      end else if (push) begin
         wr_ptr <= wr_ptr + 1'b1;
         if (count != CNT_W'(DEPTH)) count <= count + 1'b1;
      end
   end

   assign newest_idx = wr_ptr - 1'b1;
   assign rd_idx     = wr_ptr - 1'b1 - rd_depth[PTR_W-1:0];
   assign newest     = mem[newest_idx];
   assign rd_pc      = (rd_depth < count) ? mem[rd_idx] : RESET_PC;

endmodule

// File: rtl/tmr_recovery_ctrl.sv
// Recovery controller for a triple-modular-redundant core: masks transient
// single-core faults, otherwise flushes and rolls back to checkpointed PCs.
module tmr_recovery_ctrl
   import tmr_pkg::*;
#(
   parameter int          CKPT_DEPTH = 4,
   parameter int          FAULT_WIN  = 8,
   parameter int          RESYNC_CYC = 4,
   parameter int          VERIFY_WIN = 16,
   parameter logic [31:0] RESET_PC   = 32'h0
) (
   input  logic        clk,
   input  logic        rst_in,
   input  logic [2:0]  Voter_state,
   input  logic        core_hold,
   input  logic [31:0] PC_Top,
   output logic        core_stall,
   output logic        core_flush,
   output logic [31:0] PC_rollback,
   output logic        PC_rollback_valid,
   output logic [1:0]  faulty_core,
   output logic [7:0]  fault_count,
   output logic        fatal_err
);

   localparam int DEP_W   = $clog2(CKPT_DEPTH) + 1;
   localparam int WIN_A   = (FAULT_WIN > RESYNC_CYC) ? FAULT_WIN : RESYNC_CYC;
   localparam int WIN_MAX = (VERIFY_WIN > WIN_A) ? VERIFY_WIN : WIN_A;
   localparam int CNT_W   = $clog2(WIN_MAX + 1);

   decode_t          dec_q;
   logic [31:0]      pc_q;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DEP_W-1:0] depth_q, depth_d;
   logic [1:0]       faulty_d;
   logic             bump;

   logic             ring_push;
   logic [31:0]      ring_rd_pc;
   logic [DEP_W-1:0] ring_count;
   logic [31:0]      ring_newest;

   // Voter inputs are registered once; the FSM acts on the registered sample.
   always_ff @(posedge clk) begin
      if (rst_in) begin
         dec_q <= '{kind: DEC_IDLE, core: CORE_NONE};
         pc_q  <= '0;
      end else begin
         dec_q <= decode_voter(Voter_state, core_hold);
         pc_q  <= PC_Top;
      end
   end

   assign ring_push = ((state_q == ST_RUN) || (state_q == ST_MASK)) &&
                      (dec_q.kind == DEC_AGREE) &&
                      ((ring_count == '0) || (pc_q != ring_newest));

   ckpt_ring #(
      .DEPTH    (CKPT_DEPTH),
      .RESET_PC (RESET_PC)
   ) u_ring (
      .clk      (clk),
      .rst_in   (rst_in),
      .push     (ring_push),
      .pc_in    (pc_q),
      .rd_depth (depth_q),
      .rd_pc    (ring_rd_pc),
      .count    (ring_count),
      .newest   (ring_newest)
   );

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      depth_d  = depth_q;
      faulty_d = faulty_core;
      bump     = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (dec_q.kind == DEC_SINGLE) begin
               state_d  = ST_MASK;
               faulty_d = dec_q.core;
               cnt_d    = '0;
            end else if (dec_q.kind == DEC_NOMAJ) begin
               state_d = ST_STALL;
            end
         end
         ST_MASK: begin
            // cnt_q counts fault cycles after the one that entered MASK.
            if (dec_q.kind == DEC_AGREE) begin
               state_d = ST_RUN;
               bump    = 1'b1;
            end else if (dec_q.kind == DEC_SINGLE && dec_q.core == faulty_core) begin
               if (cnt_q >= CNT_W'(FAULT_WIN - 2)) begin
                  state_d = ST_RESYNC;
                  cnt_d   = '0;
                  depth_d = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (dec_q.kind != DEC_IDLE) begin
               state_d = ST_STALL;
            end
         end
         ST_STALL: begin
            state_d = ST_RESYNC;
            cnt_d   = '0;
            depth_d = '0;
         end
         ST_RESYNC: begin
            if (cnt_q == CNT_W'(RESYNC_CYC - 1)) begin
               state_d = ST_RELOAD;
               cnt_d   = '0;
               bump    = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RELOAD: begin
            state_d = ST_VERIFY;
            cnt_d   = '0;
         end
         ST_VERIFY: begin
            if (dec_q.kind == DEC_AGREE) begin
               state_d  = ST_RUN;
               depth_d  = '0;
               faulty_d = CORE_NONE;
            end else if (dec_q.kind == DEC_NOMAJ || cnt_q == CNT_W'(VERIFY_WIN - 1)) begin
               depth_d = depth_q + 1'b1;
               cnt_d   = '0;
               if (depth_d >= DEP_W'(CKPT_DEPTH) || depth_d > ring_count)
                  state_d = ST_FATAL;
               else
                  state_d = ST_RESYNC;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_FATAL: state_d = ST_FATAL;
         default:  state_d = ST_RUN;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst_in) begin
         state_q           <= ST_RUN;
         cnt_q             <= '0;
         depth_q           <= '0;
         core_stall        <= 1'b0;
         core_flush        <= 1'b0;
         PC_rollback       <= RESET_PC;
         PC_rollback_valid <= 1'b0;
         faulty_core       <= CORE_NONE;
         fault_count       <= '0;
         fatal_err         <= 1'b0;
      end else begin
         state_q           <= state_d;
         cnt_q             <= cnt_d;
         depth_q           <= depth_d;
         core_stall        <= (state_d == ST_STALL)  || (state_d == ST_RESYNC) ||
                              (state_d == ST_RELOAD) || (state_d == ST_FATAL);
         core_flush        <= (state_d == ST_RESYNC);
         PC_rollback_valid <= (state_d == ST_RELOAD);
         fatal_err         <= (state_d == ST_FATAL);
         faulty_core       <= faulty_d;
         if (state_d == ST_RELOAD) PC_rollback <= ring_rd_pc;
         if (bump && fault_count != 8'hFF) fault_count <= fault_count + 1'b1;
      end
   end

endmodule
